uart_rx_cfg: RTL

- Runtime-configurable UART receiver with an internal baud/oversample tick generator.
- Configurable oversampling, 3-sample majority vote, parity/framing/overrun/break detection.
- Sits between the synchronised serial pin and a valid/ready byte sink (FIFO or bus bridge).
- Successor to the fixed 8-bit receiver: parametrised data width (up to 9), selectable parity and stop bits, runtime baud.

---
 rtl/uart_rx_cfg_pkg.sv | 53 +++++
 rtl/uart_rx_cfg_baud_tick.sv | 26 ++
 rtl/uart_rx_cfg.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cfg_pkg.sv
// Shared UART definitions: FSM state encoding, configuration and status
// records, clamp helpers for the runtime configuration fields and a
// length-masked parity function used by receiver and transmitter.
package uart_rx_cfg_pkg;

  localparam int UART_MAX_W   = 9;
  localparam int MIN_DATA_LEN = 5;
  localparam int MIN_OSM      = 4;
  localparam int BD_DIV_W     = 8;
  localparam int BD_OSM_W     = 5;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_states;

  typedef struct packed {
    logic [3:0] data_len;
    logic       parity_en;
    logic       parity_even;
    logic       two_stop;
  } uart_config_trx;

  typedef struct packed {
    logic [BD_DIV_W-1:0] divisor;
    logic [BD_OSM_W-1:0] osm;
  } uart_config_bdgen;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic break_det;
  } uart_rx_status;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    if (int'(len) < MIN_DATA_LEN) return 4'(MIN_DATA_LEN);
    if (int'(len) > max_len) return 4'(max_len);
    return len;
  endfunction

  function automatic logic [BD_OSM_W-1:0] clamp_osm(input logic [BD_OSM_W-1:0] osm);
    if (int'(osm) < MIN_OSM) return BD_OSM_W'(MIN_OSM);
    return osm;
  endfunction

  // Expected parity bit over the low 'len' bits of data.
  function automatic logic calc_parity(input logic [UART_MAX_W-1:0] data,
                                       input logic [3:0] len, input logic even);
    logic p;
    p = 1'b0;
    for (int i = 0; i < UART_MAX_W; i++)
      if (i < int'(len)) p = p ^ data[i];
    return p ^ ~even;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_baud_tick.sv
// uart_baud_tick: free-running divisor counter producing a one-cycle
// oversample tick every divisor+1 clocks.
//   clk, rst_n : clock, async active-low reset
//   divisor    : tick period minus one
//   tick       : one-cycle oversample strobe
module uart_baud_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // '>=' rather than '==' so a divisor lowered below the running count
  // wraps at once instead of running through the whole counter range.
  assign tick = (cnt >= divisor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with oversampling,
// 3-sample majority vote and parity/framing/break/overrun detection,
// feeding a single-entry valid/ready output register.
//   cfg_*        : divisor, oversample ratio, data length, parity, stop bits
//   rx_i         : asynchronous serial input (idle high)
//   rx_data/rx_valid/rx_ready : received word handshake
//   parity_err, frame_err, break_det : status of the held word
//   overrun_err  : pulse when a completed frame is dropped
//   busy         : receiver is inside a frame
module uart_rx_cfg import uart_rx_cfg_pkg::*; #(
  parameter int MAX_DATA_W  = 9,
  parameter int DIV_W       = 8,
  parameter int OSM_W       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIV_W-1:0]      cfg_divisor,
  input  logic [OSM_W-1:0]      cfg_osm,
  input  logic [3:0]            cfg_data_len,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_parity_even,
  input  logic [1:0]            cfg_stop_len,
  input  logic                  rx_i,
  output logic [MAX_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  break_det,
  output logic                  overrun_err,
  output logic                  busy
);

  uart_states state, state_n;
  uart_config_trx trx_l;
  uart_config_bdgen bd_l;
  uart_rx_status status_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s, rx_prev, start_edge, tick;
  logic [DIV_W-1:0] tick_div;
  logic [OSM_W-1:0] osm_l, half, sample_cnt;
  logic [3:0] bit_cnt;
  logic stop_cnt, s0, s1, maj;
  logic samp_a, samp_b, samp_mid, bit_end, last_data, last_stop, complete;
  logic [MAX_DATA_W-1:0] data_sr;
  logic [UART_MAX_W-1:0] par_data;
  logic par_exp, zero_q, par_q, frm_q, brk_q, frm_now, brk_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev <= rx_s;
    end
  end

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign start_edge = rx_prev & ~rx_s;

  // While idle the tick follows the live divisor; inside a frame it uses
  // the value captured at the start edge.
  assign tick_div = (state == IDLE) ? cfg_divisor : DIV_W'(bd_l.divisor);

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .divisor (tick_div),
    .tick    (tick)
  );

  assign osm_l     = OSM_W'(bd_l.osm);
  assign half      = osm_l >> 1;
  assign samp_a    = tick && (sample_cnt == half - 1'b1);
  assign samp_b    = tick && (sample_cnt == half);
  assign samp_mid  = tick && (sample_cnt == half + 1'b1);
  assign bit_end   = tick && (sample_cnt == osm_l - 1'b1);
  assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign last_data = (bit_cnt == trx_l.data_len - 4'd1);
  assign last_stop = (stop_cnt == trx_l.two_stop);
  // Completion at the last stop bit's mid-sample so a start bit that
  // follows immediately is still seen from IDLE.
  assign complete  = (state == STOP) && samp_mid && last_stop;
  assign frm_now   = frm_q | ~maj;
  assign brk_now   = (stop_cnt == 1'b0) ? (zero_q & ~maj) : brk_q;

  always_comb begin
    par_data = '0;
    par_data[MAX_DATA_W-1:0] = data_sr;
    par_exp = calc_parity(par_data, trx_l.data_len, trx_l.parity_even);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_edge) state_n = START;
      START:   if (samp_mid && maj) state_n = IDLE;
               else if (bit_end) state_n = DATA;
      DATA:    if (bit_end && last_data) state_n = trx_l.parity_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_n = STOP;
      STOP:    if (complete) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Frame datapath: config capture, sample counting, majority samples,
  // data shift and per-frame error accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trx_l      <= '0;
      bd_l       <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      data_sr    <= '0;
      zero_q     <= 1'b0;
      par_q      <= 1'b0;
      frm_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else if (state == IDLE) begin
      if (start_edge) begin
        trx_l.data_len    <= clamp_len(cfg_data_len, MAX_DATA_W);
        trx_l.parity_en   <= cfg_parity_en;
        trx_l.parity_even <= cfg_parity_even;
        trx_l.two_stop    <= (cfg_stop_len != 2'd0);
        bd_l.divisor      <= BD_DIV_W'(cfg_divisor);
        bd_l.osm          <= clamp_osm(BD_OSM_W'(cfg_osm));
        sample_cnt        <= '0;
        bit_cnt           <= '0;
        stop_cnt          <= 1'b0;
        data_sr           <= '0;
        zero_q            <= 1'b1;
        par_q             <= 1'b0;
        frm_q             <= 1'b0;
        brk_q             <= 1'b0;
      end
    end else begin
      if (tick) sample_cnt <= bit_end ? '0 : sample_cnt + 1'b1;
      if (samp_a) s0 <= rx_s;
      if (samp_b) s1 <= rx_s;
      case (state)
        DATA: begin
          if (samp_mid) begin
            data_sr[bit_cnt] <= maj;
            if (maj) zero_q <= 1'b0;
          end
          if (bit_end) bit_cnt <= bit_cnt + 4'd1;
        end
        PARITY: begin
          if (samp_mid) begin
            par_q <= (maj != par_exp);
            if (maj) zero_q <= 1'b0;
          end
        end
        STOP: begin
          if (samp_mid) begin
            if (!maj) frm_q <= 1'b1;
            if (stop_cnt == 1'b0) brk_q <= zero_q & ~maj;
          end
          if (bit_end && !last_stop) stop_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Single-entry output register; a frame finishing while a word is
  // still held and not being accepted is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      status_q    <= '0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (complete && (!rx_valid || rx_ready)) begin
        rx_data             <= data_sr;
        rx_valid            <= 1'b1;
        status_q.parity_err <= par_q;
        status_q.frame_err  <= frm_now | brk_now;
        status_q.break_det  <= brk_now;
      end else if (complete) begin
        overrun_err <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign parity_err = status_q.parity_err;
  assign frame_err  = status_q.frame_err;
  assign break_det  = status_q.break_det;
  assign busy       = (state != IDLE);

endmodule
